// File: rtl/bmd_tlp_pkg.sv
// Shared TLP constants, state encodings and header-dword builders for the BMD
// receive/transmit engines.
package bmd_tlp_pkg;

  // {fmt[1:0], type[4:0]} as they appear in header DW0 bits [30:24]
  localparam logic [6:0] MEM_RD32 = 7'b00_00000;
  localparam logic [6:0] MEM_WR32 = 7'b10_00000;
  localparam logic [6:0] CPL      = 7'b00_01010;
  localparam logic [6:0] CPLD     = 7'b10_01010;

  localparam logic [7:0] TREM_BOTH = 8'h00;
  localparam logic [2:0] CPL_SC    = 3'b000;

  typedef enum logic [4:0] {
    ST_IDLE    = 5'b00001,
    ST_RD_WAIT = 5'b00010,
    ST_QW0     = 5'b00100,
    ST_QW1     = 5'b01000,
    ST_DONE    = 5'b10000
  } tx_state_e;

  function automatic logic [31:0] cpld_dw0(
    input logic [2:0] tc,
    input logic       td,
    input logic       ep,
    input logic [1:0] attr
  );
    return {1'b0, CPLD, 1'b0, tc, 4'b0000, td, ep, attr, 2'b00, 10'd1};
  endfunction

  function automatic logic [31:0] cpl_dw1(
    input logic [15:0] completer_id,
    input logic [11:0] byte_count
  );
    return {completer_id, CPL_SC, 1'b0, byte_count};
  endfunction

  function automatic logic [31:0] cpl_dw2(
    input logic [15:0] rid,
    input logic [7:0]  tag,
    input logic [6:0]  lower_addr
  );
    return {rid, tag, 1'b0, lower_addr};
  endfunction

endpackage

// File: rtl/bmd_cpl_hdr_calc.sv
// Completion header arithmetic for a single-DW read: byte count and lower
// address derived from the first-DW byte enables and the DW address.
module bmd_cpl_hdr_calc
  import bmd_tlp_pkg::*;
(
  input  logic [3:0]  first_be_i,
  input  logic [4:0]  addr_lo_i,
  output logic [11:0] byte_count_o,
  output logic [6:0]  lower_addr_o
);

  logic [1:0] lo2;

  // Byte count spans first to last enabled byte, holes included.
  always_comb begin
    byte_count_o = 12'd1;
    casez (first_be_i)
      4'b1??1:                     byte_count_o = 12'd4;
      4'b01?1, 4'b1?10:            byte_count_o = 12'd3;
      4'b0011, 4'b0110, 4'b1100:   byte_count_o = 12'd2;
      default:                     byte_count_o = 12'd1;
    endcase
  end

  // Byte offset of the lowest enabled byte; an empty mask reports offset 0.
  always_comb begin
    lo2 = 2'b00;
    casez (first_be_i)
      4'b???1: lo2 = 2'b00;
      4'b??10: lo2 = 2'b01;
      4'b?100: lo2 = 2'b10;
      4'b1000: lo2 = 2'b11;
      default: lo2 = 2'b00;
    endcase
  end

  assign lower_addr_o = {addr_lo_i, lo2};

endmodule

// File: rtl/bmd_cpl_tx_engine.sv
// BMD completion transmitter: turns a single-DW MemRd32 request into a 2-QW
// CplD frame on the local-link TX port. Optional macro: BMD_TX_TBUF_CHECK_EN.
module bmd_cpl_tx_engine
  import bmd_tlp_pkg::*;
#(
  parameter int RD_LATENCY  = 1,
  parameter int TBUF_W      = 6,
  parameter int CPL_BUF_BIT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_compl_i,
  output logic              compl_done_o,
  input  logic [2:0]        req_tc_i,
  input  logic              req_td_i,
  input  logic              req_ep_i,
  input  logic [1:0]        req_attr_i,
  input  logic [9:0]        req_len_i,
  input  logic [15:0]       req_rid_i,
  input  logic [7:0]        req_tag_i,
  input  logic [7:0]        req_be_i,
  input  logic [10:0]       addr_i,
  input  logic [15:0]       completer_id_i,
  output logic [10:0]       rd_addr_o,
  output logic [3:0]        rd_be_o,
  input  logic [31:0]       rd_data_i,
  output logic [63:0]       trn_td,
  output logic [7:0]        trn_trem_n,
  output logic              trn_tsof_n,
  output logic              trn_teof_n,
  output logic              trn_tsrc_rdy_n,
  output logic              trn_tsrc_dsc_n,
  input  logic              trn_tdst_rdy_n,
  input  logic              trn_tdst_dsc_n,
  input  logic [TBUF_W-1:0] trn_tbuf_av
);

  localparam logic [1:0] LAT_INIT = 2'(RD_LATENCY);

  // Handshake: a beat moves on any cycle where trn_tsrc_rdy_n and
  // trn_tdst_rdy_n are both low; until then data and sideband hold.
  tx_state_e   state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [2:0]  tc_q, tc_d;
  logic        td_q, td_d;
  logic        ep_q, ep_d;
  logic [1:0]  attr_q, attr_d;
  logic [15:0] rid_q, rid_d;
  logic [7:0]  tag_q, tag_d;
  logic [3:0]  be_q, be_d;
  logic [10:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [63:0] trn_td_q, trn_td_d;
  logic [7:0]  trem_q, trem_d;
  logic        sof_n_q, sof_n_d;
  logic        eof_n_q, eof_n_d;
  logic        src_rdy_n_q, src_rdy_n_d;
  logic        src_dsc_n_q, src_dsc_n_d;
  logic        done_q, done_d;
  logic [10:0] rd_addr_q, rd_addr_d;
  logic [3:0]  rd_be_q, rd_be_d;

  logic [11:0] byte_count;
  logic [6:0]  lower_addr;
  logic        tbuf_ok;
  logic        beat_xfer;
  logic        unused_bits;

`ifdef BMD_TX_TBUF_CHECK_EN
  assign tbuf_ok = trn_tbuf_av[CPL_BUF_BIT];
`else
  assign tbuf_ok = 1'b1;
`endif

  assign unused_bits = ^{req_len_i, req_be_i[7:4], trn_tbuf_av, trn_tbuf_av[CPL_BUF_BIT]};
  assign beat_xfer   = !src_rdy_n_q && !trn_tdst_rdy_n;

  bmd_cpl_hdr_calc u_hdr_calc (
    .first_be_i   (be_q),
    .addr_lo_i    (addr_q[4:0]),
    .byte_count_o (byte_count),
    .lower_addr_o (lower_addr)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tc_d        = tc_q;
    td_d        = td_q;
    ep_d        = ep_q;
    attr_d      = attr_q;
    rid_d       = rid_q;
    tag_d       = tag_q;
    be_d        = be_q;
    addr_d      = addr_q;
    data_d      = data_q;
    trn_td_d    = trn_td_q;
    trem_d      = trem_q;
    sof_n_d     = sof_n_q;
    eof_n_d     = eof_n_q;
    src_rdy_n_d = src_rdy_n_q;
    src_dsc_n_d = 1'b1;
    done_d      = 1'b0;
    rd_addr_d   = rd_addr_q;
    rd_be_d     = rd_be_q;

    case (state_q)
      ST_IDLE: begin
        if (req_compl_i && tbuf_ok) begin
          tc_d      = req_tc_i;
          td_d      = req_td_i;
          ep_d      = req_ep_i;
          attr_d    = req_attr_i;
          rid_d     = req_rid_i;
          tag_d     = req_tag_i;
          be_d      = req_be_i[3:0];
          addr_d    = addr_i;
          rd_addr_d = addr_i;
          rd_be_d   = req_be_i[3:0];
          cnt_d     = LAT_INIT;
          state_d   = ST_RD_WAIT;
        end
      end

      // Read data is sampled on the RD_LATENCY-th edge after rd_addr_o moves.
      ST_RD_WAIT: begin
        cnt_d = cnt_q - 2'd1;
        if (cnt_d == 2'd0) begin
          data_d      = rd_data_i;
          trn_td_d    = {cpld_dw0(tc_q, td_q, ep_q, attr_q),
                         cpl_dw1(completer_id_i, byte_count)};
          trem_d      = TREM_BOTH;
          sof_n_d     = 1'b0;
          eof_n_d     = 1'b1;
          src_rdy_n_d = 1'b0;
          state_d     = ST_QW0;
        end
      end

      ST_QW0: begin
        if (!trn_tdst_dsc_n) begin
          trn_td_d    = '0;
          trem_d      = TREM_BOTH;
          sof_n_d     = 1'b1;
          eof_n_d     = 1'b1;
          src_rdy_n_d = 1'b1;
          done_d      = 1'b1;
          state_d     = ST_DONE;
        end else if (beat_xfer) begin
          trn_td_d = {cpl_dw2(rid_q, tag_q, lower_addr), data_q};
          sof_n_d  = 1'b1;
          eof_n_d  = 1'b0;
          state_d  = ST_QW1;
        end
      end

      // A discontinue and a normal end both report done so the receive
      // engine always gets its release.
      ST_QW1: begin
        if (!trn_tdst_dsc_n || beat_xfer) begin
          trn_td_d    = '0;
          trem_d      = TREM_BOTH;
          sof_n_d     = 1'b1;
          eof_n_d     = 1'b1;
          src_rdy_n_d = 1'b1;
          done_d      = 1'b1;
          state_d     = ST_DONE;
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      tc_q        <= '0;
      td_q        <= 1'b0;
      ep_q        <= 1'b0;
      attr_q      <= '0;
      rid_q       <= '0;
      tag_q       <= '0;
      be_q        <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      trn_td_q    <= '0;
      trem_q      <= TREM_BOTH;
      sof_n_q     <= 1'b1;
      eof_n_q     <= 1'b1;
      src_rdy_n_q <= 1'b1;
      src_dsc_n_q <= 1'b1;
      done_q      <= 1'b0;
      rd_addr_q   <= '0;
      rd_be_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tc_q        <= tc_d;
      td_q        <= td_d;
      ep_q        <= ep_d;
      attr_q      <= attr_d;
      rid_q       <= rid_d;
      tag_q       <= tag_d;
      be_q        <= be_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      trn_td_q    <= trn_td_d;
      trem_q      <= trem_d;
      sof_n_q     <= sof_n_d;
      eof_n_q     <= eof_n_d;
      src_rdy_n_q <= src_rdy_n_d;
      src_dsc_n_q <= src_dsc_n_d;
      done_q      <= done_d;
      rd_addr_q   <= rd_addr_d;
      rd_be_q     <= rd_be_d;
    end
  end

  assign compl_done_o   = done_q;
  assign rd_addr_o      = rd_addr_q;
  assign rd_be_o        = rd_be_q;
  assign trn_td         = trn_td_q;
  assign trn_trem_n     = trem_q;
  assign trn_tsof_n     = sof_n_q;
  assign trn_teof_n     = eof_n_q;
  assign trn_tsrc_rdy_n = src_rdy_n_q;
  assign trn_tsrc_dsc_n = src_dsc_n_q;

endmodule

// File: tb/tb_bmd_cpl_tx_engine.sv
// Directed bench for bmd_cpl_tx_engine: expected beats are queued per request
// and a negedge monitor pops and compares every transferred beat.
module tb_bmd_cpl_tx_engine;

  localparam int RD_LAT = 3;
  localparam int W      = 75;

  logic        clk;
  logic        rst;
  logic        req_compl_i;
  logic        compl_done_o;
  logic [2:0]  req_tc_i;
  logic        req_td_i;
  logic        req_ep_i;
  logic [1:0]  req_attr_i;
  logic [9:0]  req_len_i;
  logic [15:0] req_rid_i;
  logic [7:0]  req_tag_i;
  logic [7:0]  req_be_i;
  logic [10:0] addr_i;
  logic [15:0] completer_id_i;
  logic [10:0] rd_addr_o;
  logic [3:0]  rd_be_o;
  logic [31:0] rd_data_i;
  logic [63:0] trn_td;
  logic [7:0]  trn_trem_n;
  logic        trn_tsof_n;
  logic        trn_teof_n;
  logic        trn_tsrc_rdy_n;
  logic        trn_tsrc_dsc_n;
  logic        trn_tdst_rdy_n;
  logic        trn_tdst_dsc_n;
  logic [5:0]  trn_tbuf_av;

  bmd_cpl_tx_engine #(
    .RD_LATENCY  (RD_LAT),
    .TBUF_W      (6),
    .CPL_BUF_BIT (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_compl_i    (req_compl_i),
    .compl_done_o   (compl_done_o),
    .req_tc_i       (req_tc_i),
    .req_td_i       (req_td_i),
    .req_ep_i       (req_ep_i),
    .req_attr_i     (req_attr_i),
    .req_len_i      (req_len_i),
    .req_rid_i      (req_rid_i),
    .req_tag_i      (req_tag_i),
    .req_be_i       (req_be_i),
    .addr_i         (addr_i),
    .completer_id_i (completer_id_i),
    .rd_addr_o      (rd_addr_o),
    .rd_be_o        (rd_be_o),
    .rd_data_i      (rd_data_i),
    .trn_td         (trn_td),
    .trn_trem_n     (trn_trem_n),
    .trn_tsof_n     (trn_tsof_n),
    .trn_teof_n     (trn_teof_n),
    .trn_tsrc_rdy_n (trn_tsrc_rdy_n),
    .trn_tsrc_dsc_n (trn_tsrc_dsc_n),
    .trn_tdst_rdy_n (trn_tdst_rdy_n),
    .trn_tdst_dsc_n (trn_tdst_dsc_n),
    .trn_tbuf_av    (trn_tbuf_av)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- endpoint memory: RD_LAT=3 -> two register stages ----------------
  logic [31:0] mem [0:2047];
  logic [31:0] mem_d1, mem_d2;
  always @(posedge clk) begin
    mem_d1 <= mem[rd_addr_o];
    mem_d2 <= mem_d1;
  end
  assign rd_data_i = mem_d2;

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] beat_word(input logic sof_n, input logic eof_n,
                                             input logic [63:0] td);
    return {1'b1, 8'h00, sof_n, eof_n, td};
  endfunction

  // ---------------- monitor ----------------
  initial begin
    logic [W-1:0] cur, prev_word, e;
    bit stall_prev;
    stall_prev = 1'b0;
    prev_word  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_prev = 1'b0;
      end else begin
        cur = {trn_tsrc_dsc_n, trn_trem_n, trn_tsof_n, trn_teof_n, trn_td};
        if (!trn_tsrc_rdy_n) begin
          if (stall_prev) chk("stall_hold", cur, prev_word);
          if (!trn_tdst_rdy_n && trn_tdst_dsc_n) begin
            if (exp_q.size() == 0) begin
              checks++;
              failures++;
              $display("FAIL extra_beat act=%h exp=none", cur);
            end else begin
              e = exp_q.pop_front();
              chk("beat", cur, e);
            end
          end
          stall_prev = trn_tdst_rdy_n && trn_tdst_dsc_n;
          prev_word  = cur;
        end else begin
          stall_prev = 1'b0;
        end
        if (compl_done_o) done_cnt++;
      end
    end
  end

  // ---------------- destination driver: stalls and discontinue ----------------
  int stall0 = 0;
  int stall1 = 0;
  bit dsc1   = 1'b0;
  bit dsc_pend = 1'b0;

  initial begin
    trn_tdst_rdy_n = 1'b0;
    trn_tdst_dsc_n = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (dsc_pend) begin
        chk("dsc_abort", W'({trn_tsrc_rdy_n, trn_teof_n, compl_done_o, trn_td}),
            W'({1'b1, 1'b1, 1'b1, 64'h0}));
        dsc_pend       = 1'b0;
        trn_tdst_dsc_n = 1'b1;
      end
      trn_tdst_rdy_n = 1'b0;
      if (!trn_tsrc_rdy_n && !trn_tsof_n && stall0 > 0) begin
        trn_tdst_rdy_n = 1'b1;
        stall0--;
      end else if (!trn_tsrc_rdy_n && !trn_teof_n && stall1 > 0) begin
        trn_tdst_rdy_n = 1'b1;
        stall1--;
      end else if (!trn_tsrc_rdy_n && !trn_teof_n && dsc1) begin
        trn_tdst_dsc_n = 1'b0;
        dsc1           = 1'b0;
        dsc_pend       = 1'b1;
      end
    end
  end

  // ---------------- request driver ----------------
  task automatic run_req(
    input logic [10:0] a,      input logic [3:0]  be,
    input logic [7:0]  tag,    input logic [15:0] rid,
    input logic [2:0]  tc,     input logic        td,
    input logic        ep,     input logic [1:0]  attr,
    input logic [31:0] data,   input logic [31:0] qw0_hi,
    input logic [31:0] qw0_lo, input logic [31:0] qw1_hi,
    input int          st0,    input int          st1,
    input bit          dsc,    input int          tbuf_hold,
    input bit          keep_req
  );
    logic [10:0] prev_addr;
    int cyc, n, d0;
    bit seen;
    mem[a]      = data;
    addr_i      = a;
    req_be_i    = {4'hA, be};
    req_tag_i   = tag;
    req_rid_i   = rid;
    req_tc_i    = tc;
    req_td_i    = td;
    req_ep_i    = ep;
    req_attr_i  = attr;
    req_len_i   = 10'd1;
    stall0      = st0;
    stall1      = st1;
    dsc1        = dsc;
    d0          = done_cnt;
    exp_q.push_back(beat_word(1'b0, 1'b1, {qw0_hi, qw0_lo}));
    if (!dsc) exp_q.push_back(beat_word(1'b1, 1'b0, {qw1_hi, data}));
    prev_addr = rd_addr_o;
    if (tbuf_hold > 0) trn_tbuf_av = 6'h00;
    req_compl_i = 1'b1;
`ifdef BMD_TX_TBUF_CHECK_EN
    for (int i = 0; i < tbuf_hold; i++) begin
      @(posedge clk);
      #1;
      chk("tbuf_gate", W'({rd_addr_o, trn_tsof_n}), W'({prev_addr, 1'b1}));
    end
    trn_tbuf_av = 6'h3F;
`endif
    cyc  = 0;
    seen = 1'b0;
    while (cyc < 40 && !seen) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 1) chk("rd_addr", W'({rd_be_o, rd_addr_o}), W'({be, a}));
      if (!trn_tsof_n) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL sof_timeout act=none exp=sof tag=%h", tag);
    end else begin
      chk("sof_latency", W'(cyc), W'(RD_LAT + 1));
    end
    n = 0;
    while (!compl_done_o && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!compl_done_o) begin
      checks++;
      failures++;
      $display("FAIL done_timeout act=0 exp=1 tag=%h", tag);
    end
    @(posedge clk);
    #1;
    if (!keep_req) req_compl_i = 1'b0;
    chk("done_pulse", W'(compl_done_o), W'(1'b0));
    chk("done_count", W'(done_cnt - d0), W'(1));
    chk("frame_beats", W'(exp_q.size()), W'(0));
    chk("idle_src_rdy", W'(trn_tsrc_rdy_n), W'(1'b1));
    trn_tbuf_av = 6'h3F;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 32'h0;
    rst            = 1'b1;
    req_compl_i    = 1'b0;
    req_tc_i       = '0;
    req_td_i       = 1'b0;
    req_ep_i       = 1'b0;
    req_attr_i     = '0;
    req_len_i      = 10'd1;
    req_rid_i      = '0;
    req_tag_i      = '0;
    req_be_i       = '0;
    addr_i         = '0;
    completer_id_i = 16'h0200;
    trn_tbuf_av    = 6'h3F;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_frame", W'({trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n, trn_tsrc_dsc_n}), W'(4'hF));
    chk("rst_td", W'({trn_trem_n, trn_td}), W'(0));
    chk("rst_misc", W'({compl_done_o, rd_addr_o, rd_be_o}), W'(0));
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // nominal read
    run_req(11'h004, 4'hF, 8'h2A, 16'h0100, 3'd0, 1'b0, 1'b0, 2'd0, 32'hDEADBEEF,
            32'h4A000001, 32'h02000004, 32'h01002A10, 0, 0, 1'b0, 0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    // byte-enable table at DW address 1
    run_req(11'h001, 4'h6, 8'h11, 16'h1234, 3'd0, 1'b0, 1'b0, 2'd0, 32'h11223344,
            32'h4A000001, 32'h02000002, 32'h12341105, 0, 0, 1'b0, 0, 1'b0);
    run_req(11'h001, 4'hC, 8'h12, 16'h1234, 3'd0, 1'b0, 1'b0, 2'd0, 32'h55667788,
            32'h4A000001, 32'h02000002, 32'h12341206, 0, 0, 1'b0, 0, 1'b0);
    run_req(11'h001, 4'h8, 8'h13, 16'h1234, 3'd0, 1'b0, 1'b0, 2'd0, 32'h99AABBCC,
            32'h4A000001, 32'h02000001, 32'h12341307, 0, 0, 1'b0, 0, 1'b0);
    run_req(11'h001, 4'h0, 8'h14, 16'h1234, 3'd0, 1'b0, 1'b0, 2'd0, 32'h0F0F0F0F,
            32'h4A000001, 32'h02000001, 32'h12341404, 0, 0, 1'b0, 0, 1'b0);
    // header attribute fields, top address, BE 0101
    run_req(11'h7FF, 4'h5, 8'hFE, 16'hABCD, 3'd5, 1'b1, 1'b1, 2'd2, 32'hCAFEF00D,
            32'h4A50E001, 32'h02000003, 32'hABCDFE7C, 0, 0, 1'b0, 0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    // backpressure on both beats
    run_req(11'h010, 4'h3, 8'h21, 16'h0100, 3'd0, 1'b0, 1'b0, 2'd0, 32'h01234567,
            32'h4A000001, 32'h02000002, 32'h01002140, 3, 3, 1'b0, 0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    // discontinue during QW1
    run_req(11'h020, 4'hE, 8'h31, 16'h0100, 3'd0, 1'b0, 1'b0, 2'd0, 32'h89ABCDEF,
            32'h4A000001, 32'h02000003, 32'h01003101, 0, 0, 1'b1, 0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    // normal request after abort, request held through done, then back-to-back
    // with the completion buffer bit low for 10 cycles
    run_req(11'h030, 4'h2, 8'h32, 16'h0100, 3'd0, 1'b0, 1'b0, 2'd0, 32'h13579BDF,
            32'h4A000001, 32'h02000001, 32'h01003241, 0, 0, 1'b0, 0, 1'b1);
    run_req(11'h040, 4'h9, 8'h33, 16'h0100, 3'd0, 1'b0, 1'b0, 2'd0, 32'h2468ACE0,
            32'h4A000001, 32'h02000004, 32'h01003300, 0, 0, 1'b0, 10, 1'b0);

    repeat (6) @(posedge clk);
    #1;
    chk("queue_drained", W'(exp_q.size()), W'(0));
    chk("final_idle", W'({trn_tsrc_rdy_n, compl_done_o}), W'(2'b10));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bmd_cpl_tx_engine.md
Name: bmd_cpl_tx_engine

Overview:
- 64-bit local-link transmit unit sitting directly downstream of the BMD receive engine.
- Accepts the receive engine's single-DW Memory Read 32 request: level `req_compl_i` plus captured header fields and DW address.
- Fetches the DW from endpoint memory, then emits a 2-QW Completion-with-Data TLP (3DW header + 1DW payload) to the PCIe core.
- Pulses `compl_done_i`-side handshake (`compl_done_o`) on completion.

Parameters:
- RD_LATENCY, 1, endpoint memory read latency in clk cycles from `rd_addr_o` to valid `rd_data_i`; legal 1..3.
- TBUF_W, 6, width of `trn_tbuf_av`.
- CPL_BUF_BIT, 2, `trn_tbuf_av` bit meaning "completion buffer available".

Ports:
- clk  in  1  sole clock.
- rst  in  1  synchronous active-high reset.
- req_compl_i  in  1  level request from receive engine; held until `compl_done_o` seen.
- compl_done_o  out  1  one-cycle pulse: completion sent or dropped.
- req_tc_i  in  3  TC.
- req_td_i  in  1  TD.
- req_ep_i  in  1  EP.
- req_attr_i  in  2  Attr.
- req_len_i  in  10  length (always 1).
- req_rid_i  in  16  requester ID.
- req_tag_i  in  8  tag.
- req_be_i  in  8  [3:0] first DW BE, [7:4] last DW BE (ignored).
- addr_i  in  11  DW address (byte addr [12:2]).
- completer_id_i  in  16  bus/dev/func of this endpoint.
- rd_addr_o  out  11  memory read DW address.
- rd_be_o  out  4  memory read byte enables.
- rd_data_i  in  32  memory read data.
- trn_td  out  64  TX data.
- trn_trem_n  out  8  remainder; 8'h00 = both DWs valid.
- trn_tsof_n  out  1  start of frame.
- trn_teof_n  out  1  end of frame.
- trn_tsrc_rdy_n  out  1  source ready.
- trn_tsrc_dsc_n  out  1  source discontinue; tied 1.
- trn_tdst_rdy_n  in  1  destination ready.
- trn_tdst_dsc_n  in  1  destination discontinue.
- trn_tbuf_av  in  TBUF_W  core buffer availability.

Behaviour:
- All outputs registered.
- Reset values: `trn_tsof_n`/`trn_teof_n`/`trn_tsrc_rdy_n`/`trn_tsrc_dsc_n` = 1; `trn_td` = 0; `trn_trem_n` = 8'h00; `compl_done_o` = 0; `rd_addr_o` = 0; `rd_be_o` = 0; state IDLE.
- A mid-packet `rst` abandons the frame with no `compl_done_o`.
- States (one-hot): IDLE, RD_WAIT, QW0, QW1, DONE.
- IDLE:
  - On `req_compl_i` = 1, register all request fields.
  - Drive `rd_addr_o` = `addr_i`, `rd_be_o` = `req_be_i[3:0]`.
  - Load latency counter with RD_LATENCY, then go to RD_WAIT.
- RD_WAIT:
  - Decrement the counter; at 0, capture `rd_data_i`.
  - Go to QW0, driving QW0 with `tsof_n` = 0 and `tsrc_rdy_n` = 0.
- QW0 word:
  - [63:32] = {1'b0, 7'b10_01010, 1'b0, tc, 4'b0, td, ep, attr, 2'b0, 10'd1}.
  - [31:0] = {`completer_id_i`, 3'b000 status, 1'b0 BCM, byte_count[11:0]}.
- QW1 word:
  - [63:32] = {rid, tag, 1'b0, lower_addr[6:0]}.
  - [31:0] = captured data.
  - `teof_n` = 0, `trem_n` = 8'h00.
- Beat advance: a beat transfers on a cycle where `trn_tsrc_rdy_n` = 0 and `trn_tdst_rdy_n` = 0. Data and sideband are held stable otherwise; no bubble between QW0 and QW1.
- After the QW1 transfer:
  - Deassert `tsrc_rdy_n`/`teof_n`.
  - Pulse `compl_done_o` for 1 cycle.
  - Enter DONE.
- DONE: lasts exactly 1 cycle, ignoring `req_compl_i` (still high from the receive engine), then IDLE. Back-to-back requests are therefore separated by ≥1 idle cycle.
- byte_count from first BE:
  - 1xx1 → 4.
  - 01x1 or 1x10 → 3.
  - 0011, 0110, 1100 → 2.
  - Single bit or 0000 → 1.
- lower_addr = {addr[4:0], lo2}; lo2 from BE:
  - xxx1 → 00.
  - xx10 → 01.
  - x100 → 10.
  - 1000 → 11.
  - 0000 → 00.
- Discontinue: `trn_tdst_dsc_n` = 0 in QW0 or QW1 aborts the frame. Outputs go to reset values next cycle, `compl_done_o` still pulses, and the state goes to DONE, so the receive engine never deadlocks.
- Ordering: `req_compl_i` arriving in RD_WAIT/QW0/QW1 has no effect.

Optional Feature:
- Macro: BMD_TX_TBUF_CHECK_EN.
- Defined: IDLE additionally requires `trn_tbuf_av[CPL_BUF_BIT]` = 1 before leaving. The request is held pending until the bit rises, then sampled.
- Undefined: `trn_tbuf_av` is ignored and the block starts on `req_compl_i` alone.

Decomposition:
- Package `bmd_tlp_pkg` holds:
  - fmt/type constants (MEM_RD32, MEM_WR32, CPL, CPLD), shared with the receive engine.
  - one-hot state encodings.
  - TREM_BOTH = 8'h00.
  - CPL status SC = 3'b000.
- One natural sub-module: `bmd_cpl_hdr_calc`, combinational; first BE + DW addr → byte_count[11:0] and lower_addr[6:0].

Test Plan:
- Nominal read:
  - Stimulus: `req_compl_i` = 1, addr 11'h004, BE 4'hF, tag 8'h2A, rid 16'h0100, completer 16'h0200, mem returns 32'hDEADBEEF, `tdst_rdy_n` always 0.
  - Response: QW0[31:0] = 32'h0200_0004; QW1 = {16'h0100, 8'h2A, 8'h10, 32'hDEADBEEF}; `teof_n` = 0 on QW1; `compl_done_o` one cycle after the QW1 transfer.
- BE table:
  - Stimulus: BE 4'h6, 4'hC, 4'h8, 4'h0 with addr 11'h001.
  - Response: byte_count 2/2/1/1; lower_addr 7'h05/7'h06/7'h07/7'h04.
- Backpressure:
  - Stimulus: `trn_tdst_rdy_n` = 1 for 3 cycles during QW0, then during QW1.
  - Response: `trn_td`/`tsof_n`/`teof_n` stable while stalled; exactly 2 beats transferred.
- Discontinue:
  - Stimulus: `trn_tdst_dsc_n` = 0 during QW1.
  - Response: `tsrc_rdy_n` = 1 next cycle; `compl_done_o` single pulse; next request completes normally.
- Back-to-back:
  - Stimulus: `req_compl_i` held high through `compl_done_o`, then reasserted.
  - Response: only one frame per request; ≥1 idle cycle between frames; RD_LATENCY = 3 gives QW0 exactly 3 cycles after `rd_addr_o` update.
- Macro on:
  - Stimulus: `trn_tbuf_av[2]` = 0 for 10 cycles with a request pending.
  - Response: no `rd_addr_o` update and no `tsof_n` until the bit rises; without the macro, the frame starts immediately.
